bitscan: RTL and testbench

BITSCAN -- requirements
Module: bitscan

---
 rtl/bitscan.sv | 131 +++++++++++++
 tb/tb_bitscan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bitscan.sv
// Iterative bit scanner: CLZ/CTZ/CLO/CTO/POPCNT over WIDTH bits, one CHUNK-bit slice per cycle.
// Ones-counting modes invert each slice so they share the zero-counting datapath.
module bitscan #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] M_CLZ = 3'd0;
    localparam logic [2:0] M_CTZ = 3'd1;
    localparam logic [2:0] M_CLO = 3'd2;
    localparam logic [2:0] M_CTO = 3'd3;
    localparam logic [2:0] M_POP = 3'd4;
    localparam logic [CW-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  op;
    logic [2:0]        md;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     ptr;

    int                sel;
    logic [CHUNK-1:0]  chunk;
    logic [CW-1:0]     lz, tz, pop, nxt;
    logic              found_l, found_t, last, term;

    always_comb begin
        sel     = 0;
        chunk   = '0;
        lz      = '0;
        tz      = '0;
        pop     = '0;
        found_l = 1'b0;
        found_t = 1'b0;
        nxt     = cnt;
        term    = 1'b0;
        // leading-count modes walk from the MSB slice down
        if (md == M_CLZ || md == M_CLO)
            sel = (N - 1 - int'(ptr)) * CHUNK;
        else
            sel = int'(ptr) * CHUNK;
        chunk = CHUNK'(op >> sel);
        if (md == M_CLO || md == M_CTO)
            chunk = ~chunk;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!found_l) begin
                if (chunk[i]) found_l = 1'b1;
                else          lz = lz + ONE;
            end
        end
        for (int i = 0; i < CHUNK; i++) begin
            if (!found_t) begin
                if (chunk[i]) found_t = 1'b1;
                else          tz = tz + ONE;
            end
            pop = pop + CW'(chunk[i]);
        end
        last = (ptr == PW'(N - 1));
        case (md)
            M_CLZ, M_CLO: begin
                if (found_l) begin nxt = cnt + lz; term = 1'b1; end
                else         begin nxt = cnt + CW'(CHUNK); term = last; end
            end
            M_CTZ, M_CTO: begin
                if (found_t) begin nxt = cnt + tz; term = 1'b1; end
                else         begin nxt = cnt + CW'(CHUNK); term = last; end
            end
            M_POP: begin
                nxt  = cnt + pop;
                term = last;
            end
            default: begin
                nxt  = '0;
                term = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op     <= '0;
            md     <= '0;
            cnt    <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (term) begin
                        result <= {{(WIDTH-CW){1'b0}}, nxt};
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cnt <= nxt;
                        ptr <= ptr + PW'(1);
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        op    <= a;
                        md    <= mode;
                        cnt   <= '0;
                        ptr   <= '0;
                        state <= SCAN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bitscan.sv
// Directed-vector bench for bitscan (WIDTH=32, CHUNK=4); outputs sampled on the falling edge.
module tb_bitscan;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] a = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    bitscan #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Launch one op and observe it: k = edges from accept to done (-1 on timeout).
    task automatic run_op(input logic [2:0] m, input logic [31:0] v,
                          output logic [31:0] res, output int k,
                          output int bcnt, output int dcnt);
        @(negedge clk);
        start = 1'b1; mode = m; a = v;
        @(negedge clk);
        start = 1'b0;
        k = -1; bcnt = busy ? 1 : 0; dcnt = 0; res = 'x;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (k < 0) begin k = e; res = result; end
            end
            if (k >= 0 && e >= k + 2) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; mode = 3'd4; a = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        reset = 1'b0; start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b result=%0d, required 0/0/0", busy, done, result);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_modes;
        logic [2:0]  tm [12] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6,
                                 3'd3, 3'd0, 3'd1, 3'd4, 3'd2, 3'd5};
        logic [31:0] ta [12] = '{32'h0001_0000, 32'h0, 32'h0000_0100, 32'hFFFF_FFFF,
                                 32'hF0F0_0001, 32'h1234_5678, 32'h0000_000F, 32'h8000_0000,
                                 32'h8000_0000, 32'h0, 32'hE000_0000, 32'hFFFF_FFFF};
        int          tr [12] = '{15, 32, 8, 32, 9, 0, 4, 0, 31, 0, 3, 0};
        int          tk [12] = '{4, 8, 3, 8, 8, 1, 2, 1, 8, 8, 1, 1};
        logic [31:0] res;
        int k, bc, dc;
        for (int i = 0; i < 12; i++) begin
            run_op(tm[i], ta[i], res, k, bc, dc);
            vectors++;
            if (res !== 32'(tr[i])) begin
                miscompares++;
                $display("FAIL mode_result[%0d]: mode=%0d a=%h got %0d, required %0d", i, tm[i], ta[i], res, tr[i]);
            end
            vectors++;
            if (k !== tk[i] || bc !== tk[i] || dc !== 1) begin
                miscompares++;
                $display("FAIL mode_timing[%0d]: k=%0d busy_cycles=%0d done_pulses=%0d, required k=%0d busy=%0d done=1",
                         i, k, bc, dc, tk[i], tk[i]);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int dc = 0;
        logic [31:0] res = 'x;
        @(negedge clk);
        start = 1'b1; mode = 3'd0; a = 32'h8000_0000;
        @(negedge clk);
        mode = 3'd1; a = 32'h0000_0001;   // start stays high across the SCAN edge
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_busy_scan: busy=%b, required 1", busy);
        end
        @(negedge clk);
        start = 1'b0;
        for (int e = 0; e < 12; e++) begin
            if (done) begin dc++; res = result; end
            @(negedge clk);
        end
        vectors++;
        if (res !== 32'd0 || dc !== 1) begin
            miscompares++;
            $display("FAIL ignore_busy: result=%0d done_pulses=%0d, required 0 and 1", res, dc);
        end
    endtask

    task automatic test_back_to_back;
        int k = -1;
        int held_bad = 0;
        @(negedge clk);
        start = 1'b1; mode = 3'd0; a = 32'h0001_0000;
        @(negedge clk);
        start = 1'b0;
        for (int e = 0; e < 20 && !done; e++) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || result !== 32'd15) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b result=%0d, required 1 and 15", done, result);
        end
        start = 1'b1; mode = 3'd1; a = 32'h0000_0100;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd15) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b result=%0d, required 1/0/15", busy, done, result);
        end
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (done) begin k = e; break; end
            if (result !== 32'd15) held_bad++;
        end
        vectors++;
        if (k !== 3 || result !== 32'd8 || held_bad !== 0) begin
            miscompares++;
            $display("FAIL b2b_second: k=%0d result=%0d early_changes=%0d, required k=3 result=8 0", k, result, held_bad);
        end
    endtask

    task automatic test_reset_midscan;
        int dc = 0;
        logic [31:0] res;
        int k, bc, dc2;
        @(negedge clk);
        start = 1'b1; mode = 3'd4; a = 32'hFFFF_FFFF;
        @(negedge clk);                   // 1st SCAN cycle
        start = 1'b0;
        @(negedge clk);                   // 2nd
        @(negedge clk);                   // 3rd
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_midscan: busy=%b done=%b result=%0d, required 0/0/0", busy, done, result);
        end
        for (int e = 0; e < 12; e++) begin
            if (done || busy) dc++;
            @(negedge clk);
        end
        vectors++;
        if (dc !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done: active cycles=%0d, required 0", dc);
        end
        run_op(3'd0, 32'h0001_0000, res, k, bc, dc2);
        vectors++;
        if (res !== 32'd15 || k !== 4 || dc2 !== 1) begin
            miscompares++;
            $display("FAIL after_reset_op: result=%0d k=%0d done_pulses=%0d, required 15/4/1", res, k, dc2);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
